// File: rtl/unified_cache_miss_queue_pkg.sv
// Shared constants for the unified cache miss queue: packet field layout,
// default queue depth and the per-entry state encoding.
package unified_cache_miss_queue_pkg;

  localparam int DEFAULT_NUM_ENTRY            = 4;
  localparam int DEFAULT_PACKET_WIDTH_IN_BITS = 64;
  localparam int DEFAULT_PACKET_VALID_POS     = 63;
  localparam int DEFAULT_ADDR_LSB_POS         = 0;
  localparam int DEFAULT_ADDR_WIDTH_IN_BITS   = 32;
  localparam int DEFAULT_BLOCK_SIZE_IN_BYTES  = 64;
  localparam int DEFAULT_BLOCK_OFFSET_IN_BITS = $clog2(DEFAULT_BLOCK_SIZE_IN_BYTES);

  typedef enum logic [1:0] {
    ENTRY_INVALID       = 2'd0,
    ENTRY_PENDING_ISSUE = 2'd1,
    ENTRY_WAIT_FILL     = 2'd2,
    ENTRY_READY_REPLAY  = 2'd3
  } entry_state_e;

endpackage

// File: rtl/unified_cache_miss_queue_if.sv
// Bundle of the miss-queue handshakes: enqueue from the main pipe, memory
// request/fill, and replay towards the bank input arbiter.
interface unified_cache_miss_queue_if
  import unified_cache_miss_queue_pkg::*;
#(
  parameter int PACKET_WIDTH_IN_BITS = DEFAULT_PACKET_WIDTH_IN_BITS
);

  logic [PACKET_WIDTH_IN_BITS-1:0] miss_packet_in;
  logic                            miss_packet_valid_in;
  logic                            miss_packet_ack_out;

  logic [PACKET_WIDTH_IN_BITS-1:0] miss_request_out;
  logic                            miss_request_valid_out;
  logic                            miss_request_critical_out;
  logic                            miss_request_ack_in;

  logic [PACKET_WIDTH_IN_BITS-1:0] fetched_packet_in;
  logic                            fetched_packet_valid_in;

  logic [PACKET_WIDTH_IN_BITS-1:0] replay_packet_out;
  logic                            replay_valid_out;
  logic                            replay_ack_in;

  logic                            is_full_out;

  modport slave (
    input  miss_packet_in, miss_packet_valid_in, miss_request_ack_in,
           fetched_packet_in, fetched_packet_valid_in, replay_ack_in,
    output miss_packet_ack_out, miss_request_out, miss_request_valid_out,
           miss_request_critical_out, replay_packet_out, replay_valid_out,
           is_full_out
  );

  modport master (
    output miss_packet_in, miss_packet_valid_in, miss_request_ack_in,
           fetched_packet_in, fetched_packet_valid_in, replay_ack_in,
    input  miss_packet_ack_out, miss_request_out, miss_request_valid_out,
           miss_request_critical_out, replay_packet_out, replay_valid_out,
           is_full_out
  );

endinterface

// File: rtl/unified_cache_miss_queue_lowest_index_encoder.sv
// Priority encoder: index of the lowest set bit of request_vec plus a found flag.
module lowest_index_encoder #(
  parameter int WIDTH       = 4,
  parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       request_vec,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (request_vec[i]) begin
        index = INDEX_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_cache_miss_queue.sv
// Per-bank miss status queue: captures missed packets, issues one memory
// request per distinct block, and replays packets once their fill returns.
module unified_cache_miss_queue
  import unified_cache_miss_queue_pkg::*;
#(
  parameter int NUM_ENTRY            = DEFAULT_NUM_ENTRY,
  parameter int PACKET_WIDTH_IN_BITS = DEFAULT_PACKET_WIDTH_IN_BITS,
  parameter int PACKET_VALID_POS     = DEFAULT_PACKET_VALID_POS,
  parameter int ADDR_LSB_POS         = DEFAULT_ADDR_LSB_POS,
  parameter int ADDR_WIDTH_IN_BITS   = DEFAULT_ADDR_WIDTH_IN_BITS,
  parameter int BLOCK_OFFSET_IN_BITS = DEFAULT_BLOCK_OFFSET_IN_BITS
) (
  input logic                       clk_in,
  input logic                       reset_in,
  unified_cache_miss_queue_if.slave bus
);

  localparam int IDX_W     = $clog2(NUM_ENTRY);
  localparam int BLOCK_W   = ADDR_WIDTH_IN_BITS - BLOCK_OFFSET_IN_BITS;
  localparam int BLOCK_LSB = ADDR_LSB_POS + BLOCK_OFFSET_IN_BITS;

  logic [PACKET_WIDTH_IN_BITS-1:0] packet_q [NUM_ENTRY];
  entry_state_e                    state_q  [NUM_ENTRY];
  logic [BLOCK_W-1:0]              block_q  [NUM_ENTRY];

  logic [NUM_ENTRY-1:0] free_vec;
  logic [NUM_ENTRY-1:0] pending_vec;
  logic [NUM_ENTRY-1:0] ready_vec;
  logic [NUM_ENTRY-1:0] fill_hit;
  logic [NUM_ENTRY-1:0] outstanding_hit;

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] replay_idx;
  logic             free_found;
  logic             issue_found;
  logic             replay_found;

  logic [BLOCK_W-1:0] miss_block;
  logic [BLOCK_W-1:0] fetch_block;
  logic               is_full;
  logic               enq_fire;
  logic               issue_fire;
  logic               replay_fire;
  entry_state_e       alloc_state;
  logic [PACKET_WIDTH_IN_BITS-1:0] replay_packet;
  logic               unused_fetch_bits;

  assign miss_block        = bus.miss_packet_in[BLOCK_LSB +: BLOCK_W];
  assign fetch_block       = bus.fetched_packet_in[BLOCK_LSB +: BLOCK_W];
  assign unused_fetch_bits = ^bus.fetched_packet_in;

  always_comb begin
    free_vec        = '0;
    pending_vec     = '0;
    ready_vec       = '0;
    fill_hit        = '0;
    outstanding_hit = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      free_vec[i]        = (state_q[i] == ENTRY_INVALID);
      pending_vec[i]     = (state_q[i] == ENTRY_PENDING_ISSUE);
      ready_vec[i]       = (state_q[i] == ENTRY_READY_REPLAY);
      fill_hit[i]        = bus.fetched_packet_valid_in && (block_q[i] == fetch_block);
      outstanding_hit[i] = ((state_q[i] == ENTRY_PENDING_ISSUE) ||
                            (state_q[i] == ENTRY_WAIT_FILL)) &&
                           (block_q[i] == miss_block);
    end
  end

  lowest_index_encoder #(.WIDTH(NUM_ENTRY), .INDEX_WIDTH(IDX_W)) u_free_select (
    .request_vec (free_vec),
    .index       (free_idx),
    .found       (free_found)
  );

  lowest_index_encoder #(.WIDTH(NUM_ENTRY), .INDEX_WIDTH(IDX_W)) u_issue_select (
    .request_vec (pending_vec),
    .index       (issue_idx),
    .found       (issue_found)
  );

  lowest_index_encoder #(.WIDTH(NUM_ENTRY), .INDEX_WIDTH(IDX_W)) u_replay_select (
    .request_vec (ready_vec),
    .index       (replay_idx),
    .found       (replay_found)
  );

  // Fullness comes from registered state only, so a same-cycle free never unblocks enqueue.
  assign is_full     = ~free_found;
  assign enq_fire    = bus.miss_packet_valid_in & ~is_full & reset_in;
  assign issue_fire  = issue_found & bus.miss_request_ack_in;
  assign replay_fire = replay_found & bus.replay_ack_in;

  always_comb begin
    alloc_state = ENTRY_PENDING_ISSUE;
    if (bus.fetched_packet_valid_in && (fetch_block == miss_block)) begin
      alloc_state = ENTRY_READY_REPLAY;
    end else if (|outstanding_hit) begin
      alloc_state = ENTRY_WAIT_FILL;
    end
  end

  always_comb begin
    replay_packet = '0;
    if (replay_found) begin
      replay_packet                   = packet_q[replay_idx];
      replay_packet[PACKET_VALID_POS] = 1'b1;
    end
  end

  assign bus.miss_packet_ack_out       = enq_fire;
  assign bus.miss_request_out          = issue_found ? packet_q[issue_idx] : '0;
  assign bus.miss_request_valid_out    = issue_found;
  assign bus.miss_request_critical_out = is_full;
  assign bus.replay_packet_out         = replay_packet;
  assign bus.replay_valid_out          = replay_found;
  assign bus.is_full_out               = is_full;

  // A matching fill takes priority over the issue handshake on the same entry.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        state_q[i]  <= ENTRY_INVALID;
        packet_q[i] <= '0;
        block_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (enq_fire && (free_idx == IDX_W'(i))) begin
          state_q[i]  <= alloc_state;
          packet_q[i] <= bus.miss_packet_in;
          block_q[i]  <= miss_block;
        end else begin
          case (state_q[i])
            ENTRY_PENDING_ISSUE: begin
              if (fill_hit[i]) begin
                state_q[i] <= ENTRY_READY_REPLAY;
              end else if (issue_fire && (issue_idx == IDX_W'(i))) begin
                state_q[i] <= ENTRY_WAIT_FILL;
              end
            end
            ENTRY_WAIT_FILL: begin
              if (fill_hit[i]) begin
                state_q[i] <= ENTRY_READY_REPLAY;
              end
            end
            ENTRY_READY_REPLAY: begin
              if (replay_fire && (replay_idx == IDX_W'(i))) begin
                state_q[i] <= ENTRY_INVALID;
              end
            end
            default: begin
              state_q[i] <= state_q[i];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_cache_miss_queue.sv
// Directed bench for unified_cache_miss_queue; a negedge monitor scores every
// miss-request and replay handshake against queues of hand-computed packets.
module tb_unified_cache_miss_queue;
  import unified_cache_miss_queue_pkg::*;

  localparam int PW = DEFAULT_PACKET_WIDTH_IN_BITS;

  logic clk_in = 1'b0;
  logic reset_in;

  always #5 clk_in = ~clk_in;

  unified_cache_miss_queue_if bus ();

  unified_cache_miss_queue dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_req_q[$];
  logic [PW-1:0] exp_replay_q[$];

  function automatic logic [PW-1:0] make_packet(input logic [31:0] addr, input logic [30:0] tag);
    return {1'b1, tag, addr};
  endfunction

  task automatic check_output(input string name, input logic [PW-1:0] actual,
                              input logic [PW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge for checks.
  task automatic apply_stimulus(input logic miss_v, input logic [31:0] miss_addr,
                                input logic [30:0] miss_tag, input logic req_ack,
                                input logic fetch_v, input logic [31:0] fetch_addr,
                                input logic replay_ack);
    @(posedge clk_in);
    #1;
    bus.miss_packet_valid_in    = miss_v;
    bus.miss_packet_in          = miss_v ? make_packet(miss_addr, miss_tag) : '0;
    bus.miss_request_ack_in     = req_ack;
    bus.fetched_packet_valid_in = fetch_v;
    bus.fetched_packet_in       = fetch_v ? make_packet(fetch_addr, 31'h0) : '0;
    bus.replay_ack_in           = replay_ack;
    @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    if (reset_in === 1'b1) begin
      if (bus.miss_request_valid_out && bus.miss_request_ack_in) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_request: got 0x%0h, expected none", bus.miss_request_out);
        end else begin
          check_output("miss_request", bus.miss_request_out, exp_req_q.pop_front());
        end
      end
      if (bus.replay_valid_out && bus.replay_ack_in) begin
        if (exp_replay_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_replay: got 0x%0h, expected none", bus.replay_packet_out);
        end else begin
          check_output("replay_packet", bus.replay_packet_out, exp_replay_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_in                    = 1'b0;
    bus.miss_packet_valid_in    = 1'b0;
    bus.miss_packet_in          = '0;
    bus.miss_request_ack_in     = 1'b0;
    bus.fetched_packet_valid_in = 1'b0;
    bus.fetched_packet_in       = '0;
    bus.replay_ack_in           = 1'b0;
    repeat (2) @(negedge clk_in);
    check_output("reset_req_valid", bus.miss_request_valid_out, 1'b0);
    check_output("reset_replay_valid", bus.replay_valid_out, 1'b0);
    check_output("reset_replay_packet", bus.replay_packet_out, '0);
    check_output("reset_full", bus.is_full_out, 1'b0);
    reset_in = 1'b1;

    $display("[TB] single miss 0x1000");
    apply_stimulus(1, 32'h1000, 31'd1, 0, 0, 0, 0);
    check_output("t1_ack", bus.miss_packet_ack_out, 1'b1);
    check_output("t1_req_valid_early", bus.miss_request_valid_out, 1'b0);
    exp_req_q.push_back(make_packet(32'h1000, 31'd1));
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    check_output("t1_req_valid", bus.miss_request_valid_out, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t1_req_valid_after_ack", bus.miss_request_valid_out, 1'b0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h1000, 0);
    check_output("t1_replay_before_edge", bus.replay_valid_out, 1'b0);
    exp_replay_q.push_back(make_packet(32'h1000, 31'd1));
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("t1_replay_valid", bus.replay_valid_out, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t1_replay_done", bus.replay_valid_out, 1'b0);

    $display("[TB] secondary miss in same block");
    apply_stimulus(1, 32'h1000, 31'd2, 0, 0, 0, 0);
    check_output("t2_ack0", bus.miss_packet_ack_out, 1'b1);
    apply_stimulus(1, 32'h1004, 31'd3, 0, 0, 0, 0);
    check_output("t2_ack1", bus.miss_packet_ack_out, 1'b1);
    check_output("t2_req_valid", bus.miss_request_valid_out, 1'b1);
    exp_req_q.push_back(make_packet(32'h1000, 31'd2));
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t2_single_request", bus.miss_request_valid_out, 1'b0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h1000, 0);
    exp_replay_q.push_back(make_packet(32'h1000, 31'd2));
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("t2_replay0_valid", bus.replay_valid_out, 1'b1);
    exp_replay_q.push_back(make_packet(32'h1004, 31'd3));
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("t2_replay1_valid", bus.replay_valid_out, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t2_replay_done", bus.replay_valid_out, 1'b0);

    $display("[TB] issue ack and fill on the same entry");
    apply_stimulus(1, 32'h9000, 31'd4, 0, 0, 0, 0);
    exp_req_q.push_back(make_packet(32'h9000, 31'd4));
    apply_stimulus(0, 0, 0, 1, 1, 32'h9000, 0);
    check_output("tc_req_valid", bus.miss_request_valid_out, 1'b1);
    exp_replay_q.push_back(make_packet(32'h9000, 31'd4));
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("tc_replay_valid", bus.replay_valid_out, 1'b1);
    check_output("tc_req_gone", bus.miss_request_valid_out, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("tc_replay_done", bus.replay_valid_out, 1'b0);

    $display("[TB] fill in the same cycle as enqueue");
    apply_stimulus(1, 32'h7000, 31'd5, 0, 1, 32'h7000, 0);
    check_output("t4_ack", bus.miss_packet_ack_out, 1'b1);
    exp_replay_q.push_back(make_packet(32'h7000, 31'd5));
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("t4_no_request", bus.miss_request_valid_out, 1'b0);
    check_output("t4_replay_valid", bus.replay_valid_out, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t4_replay_done", bus.replay_valid_out, 1'b0);

    $display("[TB] unmatched fill");
    apply_stimulus(0, 0, 0, 0, 1, 32'h8000, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t6_no_replay", bus.replay_valid_out, 1'b0);
    check_output("t6_no_request", bus.miss_request_valid_out, 1'b0);
    check_output("t6_not_full", bus.is_full_out, 1'b0);

    $display("[TB] fill the queue");
    apply_stimulus(1, 32'h2000, 31'd6, 0, 0, 0, 0);
    check_output("t3_ack0", bus.miss_packet_ack_out, 1'b1);
    apply_stimulus(1, 32'h3000, 31'd7, 0, 0, 0, 0);
    check_output("t3_ack1", bus.miss_packet_ack_out, 1'b1);
    apply_stimulus(1, 32'h4000, 31'd8, 0, 0, 0, 0);
    check_output("t3_ack2", bus.miss_packet_ack_out, 1'b1);
    apply_stimulus(1, 32'h5000, 31'd9, 0, 0, 0, 0);
    check_output("t3_ack3", bus.miss_packet_ack_out, 1'b1);
    apply_stimulus(1, 32'h6000, 31'd10, 0, 0, 0, 0);
    check_output("t3_full", bus.is_full_out, 1'b1);
    check_output("t3_critical", bus.miss_request_critical_out, 1'b1);
    check_output("t3_ack_blocked", bus.miss_packet_ack_out, 1'b0);
    apply_stimulus(1, 32'h6000, 31'd10, 0, 1, 32'h3000, 0);
    check_output("t3_ack_blocked_fill", bus.miss_packet_ack_out, 1'b0);
    exp_replay_q.push_back(make_packet(32'h3000, 31'd7));
    apply_stimulus(1, 32'h6000, 31'd10, 0, 0, 0, 1);
    check_output("t3_replay_valid", bus.replay_valid_out, 1'b1);
    check_output("t3_ack_same_cycle_free", bus.miss_packet_ack_out, 1'b0);
    apply_stimulus(1, 32'h6000, 31'd10, 0, 0, 0, 0);
    check_output("t3_ack_after_free", bus.miss_packet_ack_out, 1'b1);
    check_output("t3_not_full", bus.is_full_out, 1'b0);
    exp_req_q.push_back(make_packet(32'h2000, 31'd6));
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    exp_req_q.push_back(make_packet(32'h6000, 31'd10));
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t3_full_again", bus.is_full_out, 1'b1);

    $display("[TB] reset with outstanding fills");
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    #1;
    check_output("t5_req_valid", bus.miss_request_valid_out, 1'b0);
    check_output("t5_req_packet", bus.miss_request_out, '0);
    check_output("t5_replay_valid", bus.replay_valid_out, 1'b0);
    check_output("t5_full", bus.is_full_out, 1'b0);
    check_output("t5_critical", bus.miss_request_critical_out, 1'b0);
    @(negedge clk_in);
    reset_in = 1'b1;
    apply_stimulus(0, 0, 0, 0, 1, 32'h2000, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h6000, 0);
    check_output("t5_no_replay0", bus.replay_valid_out, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t5_no_replay1", bus.replay_valid_out, 1'b0);
    check_output("t5_no_reissue", bus.miss_request_valid_out, 1'b0);

    check_output("req_queue_drained", PW'(exp_req_q.size()), '0);
    check_output("replay_queue_drained", PW'(exp_replay_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_cache_miss_queue.md
Name: unified_cache_miss_queue

Overview:
- Per-bank miss status queue sitting beside the unified cache bank main pipe.
- Captures missed packets, issues one memory request per distinct block, and tracks returning fills.
- Feeds filled packets back to the bank's input arbiter as the miss-replay request; raises a full flag that the arbiter uses as replay criticality.
- Secondary misses to an outstanding block never generate a second memory request.

Parameters:
- NUM_ENTRY, 4, queue depth; must be a power of two and at least 2.
- PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, width of one cache packet.
- PACKET_VALID_POS, `UNIFIED_CACHE_PACKET_VALID_POS, bit index of the packet valid flag.
- ADDR_LSB_POS, 0, bit index of the packet address LSB.
- ADDR_WIDTH_IN_BITS, 32, packet address width.
- BLOCK_OFFSET_IN_BITS, $clog2(`UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES), address bits ignored by block match.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- miss_packet_in  input  PACKET_WIDTH_IN_BITS  missed request from the main pipe.
- miss_packet_valid_in  input  1  miss_packet_in is valid.
- miss_packet_ack_out  output  1  enqueue accepted this cycle.
- miss_request_out  output  PACKET_WIDTH_IN_BITS  memory request for a primary miss.
- miss_request_valid_out  output  1  miss_request_out is valid.
- miss_request_critical_out  output  1  equals is_full_out.
- miss_request_ack_in  input  1  memory side accepted miss_request_out.
- fetched_packet_in  input  PACKET_WIDTH_IN_BITS  fill returning from memory; only the address field is used.
- fetched_packet_valid_in  input  1  fill present; always consumed in the same cycle.
- replay_packet_out  output  PACKET_WIDTH_IN_BITS  stored packet to replay; valid bit forced to 1 when replay_valid_out is high, otherwise the whole bus is 0.
- replay_valid_out  output  1  a replay is offered.
- replay_ack_in  input  1  arbiter took the replay.
- is_full_out  output  1  every entry is occupied.

Behaviour:
- Entry states: INVALID, PENDING_ISSUE, WAIT_FILL, READY_REPLAY. Each entry holds the full packet, a 2-bit state and the block address (address >> BLOCK_OFFSET_IN_BITS).
- Reset (async, reset_in=0): all entries INVALID; all outputs 0. Outputs are combinational from registered state only; no input-to-output bypass.
- Enqueue:
  - miss_packet_ack_out = miss_packet_valid_in & ~is_full_out.
  - On ack, the lowest-index INVALID entry is allocated.
  - Initial state:
    - READY_REPLAY if a fetched_packet_valid_in in the same cycle matches the block.
    - Otherwise WAIT_FILL if any PENDING_ISSUE or WAIT_FILL entry matches the block (secondary miss).
    - Otherwise PENDING_ISSUE.
- Issue:
  - The lowest-index PENDING_ISSUE entry drives miss_request_out/valid.
  - On miss_request_ack_in that entry moves to WAIT_FILL.
  - Latency: enqueue accepted at edge N gives miss_request_valid_out=1 in cycle N+1.
- Fill:
  - Every WAIT_FILL entry whose block matches the fetched block moves to READY_REPLAY at the next edge.
  - A PENDING_ISSUE entry that matches also moves to READY_REPLAY and is never issued.
  - A fill matching no entry is ignored.
- Replay:
  - The lowest-index READY_REPLAY entry drives replay_packet_out/replay_valid_out.
  - On replay_ack_in that entry becomes INVALID at the edge; it may be reallocated from the following cycle.
  - Fill at edge M gives replay_valid_out=1 in cycle M+1.
- is_full_out is derived from registered state. A same-cycle free does not unblock enqueue (no bypass).
- Simultaneous issue-ack and fill on the same entry: the fill wins and the entry moves to READY_REPLAY.
- Acks asserted while the corresponding valid is low are ignored.
- Reset mid-operation discards all entries; no request is re-issued afterwards.

Decomposition:
- Package/parameters.h holds: entry-state encoding constants (INVALID=0, PENDING_ISSUE=1, WAIT_FILL=2, READY_REPLAY=3), packet address field position/width macros, and the NUM_ENTRY default.
- One sub-module: lowest_index_encoder (parameterised width, one-hot-to-index plus found flag).
- It is instantiated three times: free slot, issue select, replay select.

Test Plan:
- Reset, then enqueue A=0x1000 at cycle 1 -> ack=1; cycle 2 miss_request_valid_out=1 with address 0x1000; after ack, valid=0.
- Enqueue 0x1000 then 0x1004 (same 64B block) -> exactly one miss request; fill 0x1000 -> replay valid next cycle; two replays in entry order 0, 1.
- Enqueue 4 distinct blocks with no acks -> is_full_out=1, miss_request_critical_out=1; a 5th valid gets ack=0; replay_ack frees one entry -> ack=1 on the next cycle, not the same one.
- Fill arrives in the same cycle as enqueue of the matching block -> entry goes straight to READY_REPLAY; no miss request is issued.
- Drop reset_in while 2 entries are WAIT_FILL -> all outputs 0 immediately; a later fill for those blocks produces no replay.
- Fill for unmatched block 0x8000 -> no state change, no replay.
